// File: rtl/gx4000_palette_lut_if.sv
// CPU-side palette port of the GX4000 Plus colour stage.
// The CPU owns address, data and the two single-cycle strobes; the palette
// block answers a read with one registered byte qualified by cpu_dout_valid.
//
// Handshake: cpu_wr / cpu_rd are one-cycle strobes with no back-pressure.
// An accepted read always returns data on the very next cycle with
// cpu_dout_valid high for exactly that cycle; a rejected access (wrong
// mode, ASIC page not mapped, address outside the window) produces no
// write and no cpu_dout_valid. cpu_dout keeps its last value otherwise.
interface gx4000_palette_lut_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_dout;
  logic        cpu_dout_valid;

  modport master (
    output cpu_addr,
    output cpu_data,
    output cpu_wr,
    output cpu_rd,
    input  cpu_dout,
    input  cpu_dout_valid
  );

  modport slave (
    input  cpu_addr,
    input  cpu_data,
    input  cpu_wr,
    input  cpu_rd,
    output cpu_dout,
    output cpu_dout_valid
  );
endinterface

// File: rtl/gx4000_palette_lut.sv
// GX4000 Plus-mode palette lookup.
// Holds the 32 x 12-bit ASIC palette written through the ASIC RAM window,
// selects a palette index per pixel from ink / sprite pen / border state and
// outputs 4-bit RGB through a two-stage pix_en pipeline. In CPC mode the
// classic 2-bit colour is widened to 4 bits with the same latency.
module gx4000_palette_lut #(
  parameter logic [15:0] PAL_BASE    = 16'h6400,
  parameter int          PAL_ENTRIES = 32
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        plus_mode,
  input  logic        asic_unlocked,
  gx4000_palette_lut_if.slave cpu,
  input  logic        pix_en,
  input  logic        de,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [3:0]  ink,
  input  logic        spr_active,
  input  logic [3:0]  spr_ink,
  input  logic [1:0]  r_in,
  input  logic [1:0]  g_in,
  input  logic [1:0]  b_in,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out,
  output logic        out_valid
);

  // Palette entry layout is {R, G, B}, 4 bits each.
  logic [11:0] pal_q [PAL_ENTRIES];

  // CPU decode
  logic        cpu_hit;
  logic [5:0]  cpu_off;
  logic [4:0]  cpu_entry;
  logic        cpu_odd;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  rd_byte;

  logic [7:0]  cpu_dout_q;
  logic        cpu_dout_valid_q;

  // Stage 1 registers
  logic [4:0]  s1_idx_q, s1_idx_d;
  logic        s1_blank_q;
  logic        s1_plus_q;
  logic [1:0]  s1_r_q, s1_g_q, s1_b_q;
  logic        s1_vld_q;

  // Stage 2 (output) registers
  logic [11:0] rgb_q, rgb_d;
  logic        out_valid_q;

  // Window is 64 bytes starting at PAL_BASE; the base is 64-byte aligned so
  // the low six address bits give the byte offset inside the window.
  always_comb begin
    cpu_hit   = plus_mode && asic_unlocked &&
                (cpu.cpu_addr >= PAL_BASE) &&
                (cpu.cpu_addr <= (PAL_BASE + 16'd63));
    cpu_off   = cpu.cpu_addr[5:0] - PAL_BASE[5:0];
    cpu_entry = cpu_off[5:1];
    cpu_odd   = cpu_off[0];
    wr_en     = cpu.cpu_wr && cpu_hit;
    rd_en     = cpu.cpu_rd && cpu_hit;
  end

  // Readback byte from the current (pre-write) palette contents.
  always_comb begin
    rd_byte = '0;
    if (cpu_odd) begin
      rd_byte = {4'h0, pal_q[cpu_entry][7:4]};
    end else begin
      rd_byte = {pal_q[cpu_entry][11:8], pal_q[cpu_entry][3:0]};
    end
  end

  // Palette storage: each byte of an entry updates independently, so a
  // half-written colour is briefly visible, as on the real ASIC.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        pal_q[i] <= '0;
      end
    end else if (wr_en) begin
      if (cpu_odd) begin
        pal_q[cpu_entry][7:4] <= cpu.cpu_data[3:0];
      end else begin
        pal_q[cpu_entry][11:8] <= cpu.cpu_data[7:4];
        pal_q[cpu_entry][3:0]  <= cpu.cpu_data[3:0];
      end
    end
  end

  // Registered readback; data holds between reads, valid is a one-cycle pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout_q       <= '0;
      cpu_dout_valid_q <= 1'b0;
    end else begin
      cpu_dout_valid_q <= rd_en;
      if (rd_en) begin
        cpu_dout_q <= rd_byte;
      end
    end
  end

  assign cpu.cpu_dout       = cpu_dout_q;
  assign cpu.cpu_dout_valid = cpu_dout_valid_q;

  // Index selection: border wins, then a non-transparent sprite pen
  // (entries 17..31), otherwise the background ink (entries 0..15).
  always_comb begin
    s1_idx_d = {1'b0, ink};
    if (!de) begin
      s1_idx_d = 5'd16;
    end else if (spr_active && (spr_ink != 4'h0)) begin
      s1_idx_d = {1'b1, spr_ink};
    end
  end

  // Stage 1: capture the pixel description; reset leaves it blank and empty.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s1_idx_q   <= '0;
      s1_blank_q <= 1'b1;
      s1_plus_q  <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_vld_q   <= 1'b0;
    end else if (pix_en) begin
      s1_idx_q   <= s1_idx_d;
      s1_blank_q <= hblank | vblank;
      s1_plus_q  <= plus_mode;
      s1_r_q     <= r_in;
      s1_g_q     <= g_in;
      s1_b_q     <= b_in;
      s1_vld_q   <= 1'b1;
    end
  end

  // Colour for the pixel held in stage 1. The palette read sees the value
  // before any write landing on the same edge.
  always_comb begin
    rgb_d = '0;
    if (s1_blank_q) begin
      rgb_d = '0;
    end else if (s1_plus_q) begin
      rgb_d = pal_q[s1_idx_q];
    end else begin
      rgb_d = {s1_r_q, s1_r_q, s1_g_q, s1_g_q, s1_b_q, s1_b_q};
    end
  end

  // Stage 2: output registers. out_valid only pulses once stage 1 holds a
  // real pixel, so the first pulse after reset is on the second pix_en.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= pix_en && s1_vld_q;
      if (pix_en) begin
        rgb_q <= rgb_d;
      end
    end
  end

  assign r_out     = rgb_q[11:8];
  assign g_out     = rgb_q[7:4];
  assign b_out     = rgb_q[3:0];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gx4000_palette_lut.sv
// Bench for gx4000_palette_lut: directed scenarios followed by random traffic,
// checked by a scoreboard fed from a behavioural model of the palette.
module tb_gx4000_palette_lut;

  typedef struct packed {
    logic       de;
    logic       hb;
    logic       vb;
    logic [3:0] ink;
    logic       sa;
    logic [3:0] si;
    logic       plus;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } pix_t;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ---------------- DUT ----------------
  logic       plus_mode, asic_unlocked, pix_en, de, hblank, vblank;
  logic [3:0] ink, spr_ink;
  logic       spr_active;
  logic [1:0] r_in, g_in, b_in;
  logic [3:0] r_out, g_out, b_out;
  logic       out_valid;

  gx4000_palette_lut_if bus ();

  gx4000_palette_lut dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .plus_mode     (plus_mode),
    .asic_unlocked (asic_unlocked),
    .cpu           (bus),
    .pix_en        (pix_en),
    .de            (de),
    .hblank        (hblank),
    .vblank        (vblank),
    .ink           (ink),
    .spr_active    (spr_active),
    .spr_ink       (spr_ink),
    .r_in          (r_in),
    .g_in          (g_in),
    .b_in          (b_in),
    .r_out         (r_out),
    .g_out         (g_out),
    .b_out         (b_out),
    .out_valid     (out_valid)
  );

  // ---------------- reference model ----------------
  logic [11:0] pal_m [32];
  pix_t        s1_m;
  logic        s1_vld_m;
  logic [11:0] exp_q[$];
  logic [7:0]  exp_rd_q[$];

  int errors = 0;
  int checks = 0;

  function automatic logic [11:0] expect_rgb(pix_t p);
    int idx;
    if (p.hb || p.vb) return 12'h000;
    if (!p.plus) return {p.r, p.r, p.g, p.g, p.b, p.b};
    if (!p.de) idx = 16;
    else if (p.sa && p.si != 0) idx = 16 + int'(p.si);
    else idx = int'(p.ink);
    return pal_m[idx];
  endfunction

  function automatic logic [7:0] model_byte(int off);
    logic [11:0] e;
    e = pal_m[off / 2];
    if (off % 2 == 1) return {4'h0, e[7:4]};
    return {e[11:8], e[3:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pal_m[i] = 12'h000;
    s1_vld_m = 1'b0;
    exp_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Predicts the effect of the current inputs on the next edge, then clocks.
  task automatic tick();
    logic        acc;
    int          off;
    pix_t        p;
    logic [15:0] a;
    a   = bus.cpu_addr;
    acc = plus_mode && asic_unlocked && a >= 16'h6400 && a <= 16'h643F;
    off = int'(a) - 'h6400;
    if (acc && bus.cpu_rd) exp_rd_q.push_back(model_byte(off));
    if (pix_en) begin
      if (s1_vld_m) exp_q.push_back(expect_rgb(s1_m));
      p = '{de: de, hb: hblank, vb: vblank, ink: ink, sa: spr_active, si: spr_ink,
            plus: plus_mode, r: r_in, g: g_in, b: b_in};
      s1_m = p;
      s1_vld_m = 1'b1;
    end
    if (acc && bus.cpu_wr) begin
      if (off % 2 == 1) pal_m[off / 2][7:4] = bus.cpu_data[3:0];
      else begin
        pal_m[off / 2][11:8] = bus.cpu_data[7:4];
        pal_m[off / 2][3:0]  = bus.cpu_data[3:0];
      end
    end
    @(posedge clk_sys);
    #1;
    bus.cpu_wr = 1'b0;
    bus.cpu_rd = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_write(logic [15:0] a, logic [7:0] d);
    bus.cpu_addr = a;
    bus.cpu_data = d;
    bus.cpu_wr   = 1'b1;
    tick();
  endtask

  task automatic cpu_read(logic [15:0] a);
    bus.cpu_addr = a;
    bus.cpu_rd   = 1'b1;
    tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_sys) begin
    logic [11:0] e;
    logic [7:0]  d;
    if (out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected got=%h%h%h want=no_output at %0t", r_out, g_out, b_out, $time);
      end else begin
        e = exp_q.pop_front();
        if ({r_out, g_out, b_out} !== e) begin
          errors++;
          $display("FAIL pix_rgb got=%h%h%h want=%h at %0t", r_out, g_out, b_out, e, $time);
        end
      end
    end
    if (bus.cpu_dout_valid) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got=%h want=no_valid at %0t", bus.cpu_dout, $time);
      end else begin
        d = exp_rd_q.pop_front();
        if (bus.cpu_dout !== d) begin
          errors++;
          $display("FAIL rd_data got=%h want=%h at %0t", bus.cpu_dout, d, $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    plus_mode = 1'b1; asic_unlocked = 1'b1; pix_en = 1'b0;
    de = 1'b1; hblank = 1'b0; vblank = 1'b0; ink = 4'h0;
    spr_active = 1'b0; spr_ink = 4'h0; r_in = '0; g_in = '0; b_in = '0;
    bus.cpu_addr = '0; bus.cpu_data = '0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
    model_reset();

    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_rgb", {20'h0, r_out, g_out, b_out}, 32'h0);
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_dout", {24'h0, bus.cpu_dout}, 32'h0);
    chk("reset_dout_valid", {31'h0, bus.cpu_dout_valid}, 32'h0);
    reset_n = 1'b1;
    #1;

    // Palette write and display: entry 1 = F/A/0
    cpu_write(16'h6402, 8'hF0);
    cpu_write(16'h6403, 8'h0A);
    ink = 4'h1; pix_en = 1'b1;
    tick();
    chk("first_pix_no_valid", {31'h0, out_valid}, 32'h0);
    tick();
    chk("entry1_valid", {31'h0, out_valid}, 32'h1);
    chk("entry1_rgb", {20'h0, r_out, g_out, b_out}, 32'hFA0);
    tick();

    // Readback: upper nibble of odd byte dropped
    cpu_write(16'h6403, 8'hFA);
    cpu_read(16'h6403);
    chk("readback_data", {24'h0, bus.cpu_dout}, 32'h0A);
    chk("readback_valid", {31'h0, bus.cpu_dout_valid}, 32'h1);
    tick();
    chk("readback_hold", {24'h0, bus.cpu_dout}, 32'h0A);
    asic_unlocked = 1'b0;
    cpu_write(16'h6403, 8'h05);
    cpu_read(16'h6403);
    chk("locked_no_valid", {31'h0, bus.cpu_dout_valid}, 32'h0);
    asic_unlocked = 1'b1;
    cpu_read(16'h6403);
    cpu_read(16'h6440);
    cpu_read(16'h63FF);

    // Border and blank
    cpu_write(16'h6420, 8'h57);
    cpu_write(16'h6421, 8'h06);
    de = 1'b0;
    ticks(2);
    chk("border_rgb", {20'h0, r_out, g_out, b_out}, 32'h567);
    vblank = 1'b1;
    ticks(2);
    chk("vblank_rgb", {20'h0, r_out, g_out, b_out}, 32'h000);
    vblank = 1'b0; de = 1'b1;

    // Sprite priority: entry 19 = 0/0/F
    cpu_write(16'h6426, 8'h0F);
    cpu_write(16'h6427, 8'h00);
    spr_active = 1'b1; spr_ink = 4'h3;
    ticks(2);
    chk("sprite_rgb", {20'h0, r_out, g_out, b_out}, 32'h00F);
    spr_ink = 4'h0;
    ticks(2);
    chk("sprite_transparent_rgb", {20'h0, r_out, g_out, b_out}, 32'hFA0);
    spr_active = 1'b0;

    // CPC pass-through
    plus_mode = 1'b0; r_in = 2'd1; g_in = 2'd2; b_in = 2'd3;
    ticks(2);
    chk("cpc_rgb", {20'h0, r_out, g_out, b_out}, 32'h5AF);
    plus_mode = 1'b1;
    ticks(2);

    // Write hazard: write entry 1 while its lookup is in stage 2
    cpu_write(16'h6402, 8'h30);
    chk("hazard_old", {20'h0, r_out, g_out, b_out}, 32'hFA0);
    tick();
    chk("hazard_new", {20'h0, r_out, g_out, b_out}, 32'h3A0);
    tick();

    // Asynchronous reset mid-stream
    @(negedge clk_sys);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", {20'h0, r_out, g_out, b_out}, 32'h0);
    chk("async_rst_dout", {24'h0, bus.cpu_dout}, 32'h0);
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    pix_en = 1'b0;
    cpu_read(16'h6402);
    pix_en = 1'b1;
    tick();
    chk("post_rst_first_no_valid", {31'h0, out_valid}, 32'h0);
    tick();
    chk("post_rst_second_valid", {31'h0, out_valid}, 32'h1);
    chk("post_rst_cleared_rgb", {20'h0, r_out, g_out, b_out}, 32'h000);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      pix_en        = ($urandom_range(0, 3) != 0);
      plus_mode     = ($urandom_range(0, 7) != 0);
      asic_unlocked = ($urandom_range(0, 9) != 0);
      de            = ($urandom_range(0, 5) != 0);
      hblank        = ($urandom_range(0, 9) == 0);
      vblank        = ($urandom_range(0, 15) == 0);
      ink           = 4'($urandom_range(0, 15));
      spr_active    = ($urandom_range(0, 2) == 0);
      spr_ink       = 4'($urandom_range(0, 15));
      r_in          = 2'($urandom_range(0, 3));
      g_in          = 2'($urandom_range(0, 3));
      b_in          = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        bus.cpu_addr = 16'($urandom_range(16'h63F0, 16'h644F));
        bus.cpu_data = 8'($urandom_range(0, 255));
        bus.cpu_wr   = ($urandom_range(0, 1) == 1);
        bus.cpu_rd   = ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    // Drain and confirm nothing is left outstanding
    pix_en = 1'b0;
    ticks(4);
    chk("pix_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("rd_queue_drained", 32'(exp_rd_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
